pixel_dispatcher: RTL

Frame-level scheduler that walks every pixel of the frame in raster order and hands each (x, y) coordinate to one of up to four ray-tracing cores in strict round-robin order. The order matches the order in which the downstream pixel buffer drains the cores, so the output stream stays in raster order. The dispatcher sits between the frame-start control and the compute cores' coordinate inputs.

---
 rtl/raytrace_pkg.sv | 21 ++
 rtl/raster_counter.sv | 39 +++
 rtl/pixel_dispatcher.sv | 115 +++++++++++
 3 files changed

// File: rtl/raytrace_pkg.sv
// Shared types and constants for the ray-tracing front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package raytrace_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    DONE     = 2'd2
  } dispatch_state_t;

  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;
  localparam int MAX_CORES    = 4;

  // Active core count from the "extra cores" request, clamped to the slots we have.
  function automatic logic [2:0] clamp_active(input logic [2:0] extra);
    return (extra > 3'(MAX_CORES - 1)) ? 3'(MAX_CORES) : (extra + 3'd1);
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster-order x/y coordinate counter with frame-end flag.
// Latency: coordinate updates one cycle after advance; last is combinational from the count.
// Backpressure: holds whenever advance is low.
module raster_counter #(
  parameter int W  = 640,
  parameter int H  = 480,
  parameter int XW = $clog2(W),
  parameter int YW = $clog2(H)
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          advance,
  input  logic          clear,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last
);

  localparam logic [XW-1:0] X_MAX = XW'(W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(H - 1);

  // Step through the frame one pixel per advance, wrapping x into y and y back to 0.
  always_ff @(posedge aclk) begin
    if (!aresetn || clear) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (x == X_MAX) begin
        x <= '0;
        y <= (y == Y_MAX) ? '0 : (y + YW'(1));
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  assign last = (x == X_MAX) && (y == Y_MAX);

endmodule

// File: rtl/pixel_dispatcher.sv
// Walks the frame in raster order and offers each pixel to cores in strict round robin.
// Latency: first coordinate offered the cycle after start; one pixel per cycle when ready.
// Backpressure: coordinate and core index hold while the addressed core is not ready.
// Optional stall counter output enabled by PIXEL_DISPATCHER_STALL_CNT_EN.
module pixel_dispatcher
  import raytrace_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int XW       = $clog2(SCREEN_W),
  parameter int YW       = $clog2(SCREEN_H)
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 start,
  input  logic [2:0]           no_of_extra_cores,
  input  logic [MAX_CORES-1:0] core_ready,
  output logic [MAX_CORES-1:0] core_valid,
  output logic [XW-1:0]        out_x,
  output logic [YW-1:0]        out_y,
  output logic                 sof,
  output logic                 busy,
  output logic                 frame_done
`ifdef PIXEL_DISPATCHER_STALL_CNT_EN
  ,
  output logic [31:0]          stall_cycles
`endif
);

  dispatch_state_t state_q, state_d;
  logic [2:0] n_active;
  logic [1:0] next_core;
  logic       accept_start;
  logic       xfer;
  logic       last;

  raster_counter #(
    .W (SCREEN_W),
    .H (SCREEN_H),
    .XW(XW),
    .YW(YW)
  ) u_raster (
    .aclk   (aclk),
    .aresetn(aresetn),
    .advance(xfer),
    .clear  (accept_start),
    .x      (out_x),
    .y      (out_y),
    .last   (last)
  );

  // State register.
  always_ff @(posedge aclk) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state and outputs; offers depend only on registered state, never on core_ready.
  always_comb begin
    state_d      = state_q;
    core_valid   = '0;
    sof          = 1'b0;
    busy         = 1'b0;
    frame_done   = 1'b0;
    accept_start = 1'b0;
    xfer         = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept_start = 1'b1;
          state_d      = DISPATCH;
        end
      end
      DISPATCH: begin
        busy                  = 1'b1;
        core_valid[next_core] = 1'b1;
        sof                   = (out_x == '0) && (out_y == '0);
        xfer                  = core_ready[next_core];
        if (xfer && last) state_d = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        frame_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Round-robin pointer; core count is frozen for the frame when start is accepted.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      n_active  <= 3'd1;
      next_core <= 2'd0;
    end else if (accept_start) begin
      n_active  <= clamp_active(no_of_extra_cores);
      next_core <= 2'd0;
    end else if (xfer) begin
      next_core <= ({1'b0, next_core} == (n_active - 3'd1)) ? 2'd0 : (next_core + 2'd1);
    end
  end

`ifdef PIXEL_DISPATCHER_STALL_CNT_EN
  // Count cycles the addressed core refused an offer; saturates rather than wrapping.
  always_ff @(posedge aclk) begin
    if (!aresetn || accept_start) begin
      stall_cycles <= '0;
    end else if ((state_q == DISPATCH) && !core_ready[next_core] &&
                 (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule
